// File: rtl/rand_checker_if.sv
// rand_checker_if: sample stream into the checker plus its status outputs.
// Handshake: valid-only, no back-pressure. When valid=1 on a rising edge,
// din is consumed on that edge; when valid=0, din is ignored. The checker
// never stalls, so a producer may hold valid high every cycle.
interface rand_checker_if #(
  parameter int CNT_W = 8
);
  logic             valid;
  logic [3:1]       din;
  logic             locked;
  logic             err;
  logic [CNT_W-1:0] err_cnt;
  logic             stuck;
  logic             period_err;

  // Producer side (generator / test driver)
  modport master (
    output valid, din,
    input  locked, err, err_cnt, stuck, period_err
  );

  // Checker side
  modport slave (
    input  valid, din,
    output locked, err, err_cnt, stuck, period_err
  );
endinterface

// File: rtl/rand_checker.sv
// rand_checker: self-synchronising checker for the 3-bit LFSR stream
// next(x) = {x[2], x[1], x[3]^x[2]} (period 7, 000 illegal).
// SEARCH seeds a prediction, VERIFY needs LOCK_CNT consecutive hits to lock,
// LOCKED flywheels the prediction and drops lock after LOSS_CNT misses.
// Optional period monitor built when RAND_CHECKER_PERIOD_EN is defined;
// otherwise period_err is tied to 0.
// dbg_state encoding: 0 = SEARCH, 1 = VERIFY, 2 = LOCKED.
module rand_checker #(
  parameter int LOCK_CNT = 3,
  parameter int LOSS_CNT = 2,
  parameter int CNT_W    = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  rand_checker_if.slave       bus,
  output logic [1:0]          dbg_state
);

  localparam int MW = $clog2(LOCK_CNT + 1);
  localparam int LW = $clog2(LOSS_CNT + 1);

  typedef enum logic [1:0] {
    S_SEARCH = 2'd0,
    S_VERIFY = 2'd1,
    S_LOCKED = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [3:1]       pred_q, pred_d;
  logic [MW-1:0]    match_cnt_q, match_cnt_d;
  logic [LW-1:0]    miss_cnt_q, miss_cnt_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic             err_q, err_d;
  logic             stuck_q, stuck_d;
  logic             perr_q, perr_d;

  logic             hit;
  logic             din_zero;
  logic [MW-1:0]    match_inc;
  logic [LW-1:0]    miss_inc;

  function automatic logic [3:1] lfsr_next(input logic [3:1] x);
    return {x[2], x[1], x[3] ^ x[2]};
  endfunction

  assign hit       = (bus.din == pred_q);
  assign din_zero  = (bus.din == 3'b000);
  assign match_inc = match_cnt_q + MW'(1);
  assign miss_inc  = miss_cnt_q + LW'(1);

  // Next-state and counter updates; only valid samples change anything
  always_comb begin
    state_d     = state_q;
    pred_d      = pred_q;
    match_cnt_d = match_cnt_q;
    miss_cnt_d  = miss_cnt_q;
    err_cnt_d   = err_cnt_q;
    err_d       = 1'b0;
    stuck_d     = stuck_q;
    if (bus.valid) begin
      stuck_d = din_zero;
      unique case (state_q)
        S_SEARCH: begin
          if (!din_zero) begin
            pred_d      = lfsr_next(bus.din);
            match_cnt_d = '0;
            state_d     = S_VERIFY;
          end
        end
        S_VERIFY: begin
          if (din_zero) begin
            state_d = S_SEARCH;
          end else if (hit) begin
            match_cnt_d = match_inc;
            pred_d      = lfsr_next(bus.din);
            if (match_inc == MW'(LOCK_CNT)) begin
              state_d    = S_LOCKED;
              miss_cnt_d = '0;
            end
          end else begin
            // Re-seed from the new sample rather than falling back to SEARCH
            pred_d      = lfsr_next(bus.din);
            match_cnt_d = '0;
          end
        end
        S_LOCKED: begin
          // Flywheel: advance from our own prediction so one bad sample
          // cannot re-seed the sequence
          pred_d = lfsr_next(pred_q);
          if (hit) begin
            miss_cnt_d = '0;
          end else begin
            err_d      = 1'b1;
            if (err_cnt_q != {CNT_W{1'b1}}) err_cnt_d = err_cnt_q + CNT_W'(1);
            miss_cnt_d = miss_inc;
            if (miss_inc == LW'(LOSS_CNT)) state_d = S_SEARCH;
          end
        end
        default: state_d = S_SEARCH;
      endcase
    end
  end

  // Main state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_SEARCH;
      pred_q      <= 3'b000;
      match_cnt_q <= '0;
      miss_cnt_q  <= '0;
      err_cnt_q   <= '0;
      err_q       <= 1'b0;
      stuck_q     <= 1'b0;
      perr_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      pred_q      <= pred_d;
      match_cnt_q <= match_cnt_d;
      miss_cnt_q  <= miss_cnt_d;
      err_cnt_q   <= err_cnt_d;
      err_q       <= err_d;
      stuck_q     <= stuck_d;
      perr_q      <= perr_d;
    end
  end

`ifdef RAND_CHECKER_PERIOD_EN
  // per_cnt holds the valid samples seen since the last 001 (saturates at 7);
  // a correct period means it reads 6 when the next 001 arrives
  logic [2:0] per_cnt_q, per_cnt_d;
  logic       per_arm_q, per_arm_d;
  logic       enter_lock;

  assign enter_lock = (state_q != S_LOCKED) && (state_d == S_LOCKED);

  // Period monitor: counter cleared on lock entry, first 001 only arms it
  always_comb begin
    per_cnt_d = per_cnt_q;
    per_arm_d = per_arm_q;
    perr_d    = 1'b0;
    if (enter_lock) begin
      per_cnt_d = 3'd0;
      per_arm_d = 1'b0;
    end else if (state_q == S_LOCKED && bus.valid) begin
      if (bus.din == 3'b001) begin
        perr_d    = per_arm_q && (per_cnt_q != 3'd6);
        per_arm_d = 1'b1;
        per_cnt_d = 3'd0;
      end else if (per_cnt_q != 3'd7) begin
        per_cnt_d = per_cnt_q + 3'd1;
      end
    end
  end

  // Period monitor registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      per_cnt_q <= 3'd0;
      per_arm_q <= 1'b0;
    end else begin
      per_cnt_q <= per_cnt_d;
      per_arm_q <= per_arm_d;
    end
  end
`else
  assign perr_d = 1'b0;
`endif

  assign bus.locked     = (state_q == S_LOCKED);
  assign bus.err        = err_q;
  assign bus.err_cnt    = err_cnt_q;
  assign bus.stuck      = stuck_q;
  assign bus.period_err = perr_q;
  assign dbg_state      = state_q;

endmodule

// File: tb/tb_rand_checker.sv
// tb_rand_checker: drives two checkers (CNT_W=8 and CNT_W=2) with the same
// clean/corrupted LFSR stream and compares every output against a
// table-driven reference model of the lock/flywheel rules.
`timescale 1ns/1ps
module tb_rand_checker;

  localparam int LOCK_CNT = 3;
  localparam int LOSS_CNT = 2;
  localparam int M_SEARCH = 0;
  localparam int M_VERIFY = 1;
  localparam int M_LOCKED = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  rand_checker_if #(.CNT_W(8)) bus_a();
  rand_checker_if #(.CNT_W(2)) bus_b();
  logic [1:0] dbg_a, dbg_b;

  rand_checker #(.LOCK_CNT(LOCK_CNT), .LOSS_CNT(LOSS_CNT), .CNT_W(8)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(bus_a.slave), .dbg_state(dbg_a)
  );
  rand_checker #(.LOCK_CNT(LOCK_CNT), .LOSS_CNT(LOSS_CNT), .CNT_W(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(bus_b.slave), .dbg_state(dbg_b)
  );

  initial begin
    #1000000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  // ---------------- reference model ----------------
  logic [3:1] seq_tab [7] = '{3'd1, 3'd2, 3'd5, 3'd3, 3'd7, 3'd6, 3'd4};
  int         m_st, m_match, m_miss, m_cnt_a, m_cnt_b;
  logic [3:1] m_pred;
  logic       m_err, m_stuck, m_perr;
`ifdef RAND_CHECKER_PERIOD_EN
  logic       p_armed;
  int         p_cnt;
`endif
  logic [15:0] exp_q[$];
  int n_checks = 0;
  int n_errors = 0;
  int gi = 0;

  function automatic logic [3:1] succ(input logic [3:1] x);
    for (int i = 0; i < 7; i++)
      if (seq_tab[i] == x) return seq_tab[(i + 1) % 7];
    return 3'b000;
  endfunction

  task automatic model_push();
    exp_q.push_back({2'(m_st), (m_st == M_LOCKED), m_err, 8'(m_cnt_a), 2'(m_cnt_b), m_stuck, m_perr});
  endtask

  task automatic model_reset();
    m_st = M_SEARCH; m_match = 0; m_miss = 0; m_cnt_a = 0; m_cnt_b = 0;
    m_pred = 3'b000; m_err = 1'b0; m_stuck = 1'b0; m_perr = 1'b0;
`ifdef RAND_CHECKER_PERIOD_EN
    p_armed = 1'b0; p_cnt = 0;
`endif
    model_push();
  endtask

  task automatic model_step(input logic v, input logic [3:1] d);
    m_err = 1'b0;
    m_perr = 1'b0;
    if (v) begin
      m_stuck = (d == 3'b000);
      if (m_st == M_SEARCH) begin
        if (d != 3'b000) begin m_pred = succ(d); m_match = 0; m_st = M_VERIFY; end
      end else if (m_st == M_VERIFY) begin
        if (d == 3'b000) m_st = M_SEARCH;
        else if (d == m_pred) begin
          m_match++;
          m_pred = succ(d);
          if (m_match == LOCK_CNT) begin
            m_st = M_LOCKED; m_miss = 0;
`ifdef RAND_CHECKER_PERIOD_EN
            p_armed = 1'b0; p_cnt = 0;
`endif
          end
        end else begin
          m_pred = succ(d); m_match = 0;
        end
      end else begin
`ifdef RAND_CHECKER_PERIOD_EN
        if (d == 3'b001) begin
          if (p_armed && (p_cnt + 1 != 7)) m_perr = 1'b1;
          p_armed = 1'b1; p_cnt = 0;
        end else p_cnt++;
`endif
        if (d == m_pred) m_miss = 0;
        else begin
          m_err = 1'b1;
          if (m_cnt_a < 255) m_cnt_a++;
          if (m_cnt_b < 3) m_cnt_b++;
          m_miss++;
          if (m_miss == LOSS_CNT) m_st = M_SEARCH;
        end
        m_pred = succ(m_pred);
      end
    end
    model_push();
  endtask

  // ---------------- scoreboard ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    logic [15:0] e;
    e = exp_q.pop_front();
    chk("state_a",   32'(dbg_a),            32'(e[15:14]));
    chk("locked_a",  32'(bus_a.locked),     32'(e[13]));
    chk("err_a",     32'(bus_a.err),        32'(e[12]));
    chk("errcnt_a",  32'(bus_a.err_cnt),    32'(e[11:4]));
    chk("stuck_a",   32'(bus_a.stuck),      32'(e[1]));
    chk("perr_a",    32'(bus_a.period_err), 32'(e[0]));
    chk("state_b",   32'(dbg_b),            32'(e[15:14]));
    chk("locked_b",  32'(bus_b.locked),     32'(e[13]));
    chk("err_b",     32'(bus_b.err),        32'(e[12]));
    chk("errcnt_b",  32'(bus_b.err_cnt),    32'(e[3:2]));
    chk("stuck_b",   32'(bus_b.stuck),      32'(e[1]));
    chk("perr_b",    32'(bus_b.period_err), 32'(e[0]));
  endtask

  // ---------------- driver tasks ----------------
  task automatic cycle(input logic v, input logic [3:1] d);
    @(negedge clk);
    bus_a.valid = v; bus_a.din = d;
    bus_b.valid = v; bus_b.din = d;
    @(posedge clk);
    model_step(v, d);
    #1;
    check_outputs();
  endtask

  task automatic send_clean();
    cycle(1'b1, seq_tab[gi]);
    gi = (gi + 1) % 7;
  endtask

  task automatic send_bad();
    logic [3:1] b;
    b = 3'($urandom_range(1, 7));
    while (b == seq_tab[gi]) b = 3'($urandom_range(1, 7));
    cycle(1'b1, b);
    gi = (gi + 1) % 7;
  endtask

  task automatic send_gap();
    cycle(1'b0, 3'($urandom_range(0, 7)));
  endtask

  task automatic lock_up();
    for (int i = 0; i < 4; i++) send_clean();
    chk("lock_up", 32'(bus_a.locked), 32'd1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bus_a.valid = 1'b0; bus_a.din = 3'b000;
    bus_b.valid = 1'b0; bus_b.din = 3'b000;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_outputs();
    @(negedge clk);
    rst_n = 1'b1;

    // Clean stream from 001: locked appears after the 4th sample
    for (int i = 0; i < 4; i++) begin
      send_clean();
      chk("lock_latency", 32'(bus_a.locked), (i == 3) ? 32'd1 : 32'd0);
    end
    for (int i = 0; i < 50; i++) send_clean();
    chk("clean_errcnt", 32'(bus_a.err_cnt), 32'd0);

    // Single corrupt sample: 101 replaced by 110
    for (int i = 0; i < 7 && seq_tab[gi] != 3'b101; i++) send_clean();
    cycle(1'b1, 3'b110);
    gi = (gi + 1) % 7;
    chk("single_err", 32'(bus_a.err), 32'd1);
    chk("single_cnt", 32'(bus_a.err_cnt), 32'd1);
    chk("single_locked", 32'(bus_a.locked), 32'd1);
    for (int i = 0; i < 10; i++) send_clean();
    chk("single_recover", 32'(bus_a.err_cnt), 32'd1);

    // Two consecutive misses drop lock; 4 clean samples re-lock
    send_bad();
    chk("double_first_locked", 32'(bus_a.locked), 32'd1);
    send_bad();
    chk("double_second_err", 32'(bus_a.err), 32'd1);
    chk("double_unlocked", 32'(bus_a.locked), 32'd0);
    for (int i = 0; i < 4; i++) begin
      send_clean();
      chk("relock", 32'(bus_a.locked), (i == 3) ? 32'd1 : 32'd0);
    end
    chk("double_cnt_sat_b", 32'(bus_b.err_cnt), 32'd3);

    // Stream of 000: stuck, no lock
    for (int i = 0; i < 6; i++) cycle(1'b1, 3'b000);
    chk("zero_stuck", 32'(bus_a.stuck), 32'd1);
    chk("zero_locked", 32'(bus_a.locked), 32'd0);

    // Gaps inside a clean stream do not disturb lock
    lock_up();
    for (int i = 0; i < 30; i++) begin
      if ($urandom_range(0, 2) == 0) send_gap();
      else send_clean();
    end
    chk("gaps_locked", 32'(bus_a.locked), 32'd1);

    // Randomized mix of clean, corrupt, gaps and 000
    for (int i = 0; i < 300; i++) begin
      int r;
      r = int'($urandom_range(0, 19));
      if (r == 0) begin
        cycle(1'b1, 3'b000);
      end else if (r <= 2) send_bad();
      else if (r <= 4) send_gap();
      else send_clean();
    end

    // Asynchronous reset mid-stream: outputs clear without a clock edge
    lock_up();
    @(negedge clk);
    bus_a.valid = 1'b0; bus_b.valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_outputs();
    @(negedge clk);
    rst_n = 1'b1;

    // Five isolated errors: CNT_W=2 saturates at 3, CNT_W=8 reaches 5
    for (int k = 0; k < 5; k++) begin
      lock_up();
      send_bad();
      for (int i = 0; i < 3; i++) send_clean();
    end
    chk("sat_cnt_b", 32'(bus_b.err_cnt), 32'd3);
    chk("sat_cnt_a", 32'(bus_a.err_cnt), 32'd5);

`ifdef RAND_CHECKER_PERIOD_EN
    // Drop the sample just before a 001: period 6 is flagged
    lock_up();
    for (int i = 0; i < 20; i++) send_clean();
    for (int i = 0; i < 7 && seq_tab[gi] != 3'b100; i++) send_clean();
    gi = (gi + 1) % 7;
    send_clean();
    chk("period_err_pulse", 32'(bus_a.period_err), 32'd1);
    for (int i = 0; i < 20; i++) send_clean();
`endif

    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
